// File: rtl/pooled_pixel_streamer.sv
// pooled_pixel_streamer: captures a flat pooled frame on start and streams it
// out one pixel per valid/ready transfer in index order, then pulses done.
module pooled_pixel_streamer #(
    parameter int resolution    = 8,
    parameter int pixels_number = 196,
    parameter int addr_width    = $clog2(pixels_number)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [resolution*pixels_number-1:0] pixels_averaged,
    output logic                                busy,
    output logic [resolution-1:0]               pixel_out,
    output logic [addr_width-1:0]               pixel_addr,
    output logic                                pixel_valid,
    input  logic                                pixel_ready,
    output logic                                last,
    output logic                                done
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    localparam logic [addr_width-1:0] last_addr = addr_width'(pixels_number - 1);

    state_t                               state;
    state_t                               state_next;
    logic [resolution*pixels_number-1:0]  snapshot;
    logic                                 capture;
    logic                                 xfer;
    logic                                 at_last;

    // start is only honoured from IDLE; a start seen in DONE is simply dropped
    assign capture = (state == IDLE) && start;
    assign xfer    = pixel_valid && pixel_ready;
    assign at_last = (pixel_addr == last_addr);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values and simulation order cannot matter.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> STREAM on start, STREAM -> DONE after the last
    // transfer, DONE lasts exactly one cycle
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start)           state_next = STREAM;
            STREAM:  if (xfer && at_last) state_next = DONE;
            DONE:                         state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // Snapshot capture and pixel index; index only moves on an accepted transfer
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the wide snapshot register is reset on purpose so a reset frame
        // can never leak stale pixel data; it is a register, not a RAM.
        if (reset) begin
            snapshot   <= '0;
            pixel_addr <= '0;
        end else if (capture) begin
            snapshot   <= pixels_averaged;
            pixel_addr <= '0;
        end else if (xfer) begin
            pixel_addr <= at_last ? '0 : pixel_addr + 1'b1;
        end
    end

    // Outputs are decoded from registers only, so they hold under backpressure
    assign pixel_valid = (state == STREAM);
    assign busy        = (state == STREAM) || (state == DONE);
    assign done        = (state == DONE);
    assign last        = pixel_valid && at_last;
    assign pixel_out   = pixel_valid ? snapshot[pixel_addr*resolution +: resolution]
                                     : '0;

endmodule

// File: tb/tb_pooled_pixel_streamer.sv
// tb_pooled_pixel_streamer: scoreboard bench; stimulus pushes the expected
// pixel stream into a queue and monitors pop and compare on each transfer.
module tb_pooled_pixel_streamer;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } exp_t;

    int passed = 0;
    int total  = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // default-size instance
    logic          start = 1'b0;
    logic          pixel_ready = 1'b1;
    logic [1567:0] pix = '0;
    logic          busy, pixel_valid, last, done;
    logic [7:0]    pixel_out;
    logic [7:0]    pixel_addr;

    // small instance: resolution=4, pixels_number=16
    logic          start_s = 1'b0;
    logic          ready_s = 1'b1;
    logic [63:0]   pix_s = '0;
    logic          busy_s, valid_s, last_s, done_s;
    logic [3:0]    out_s;
    logic [3:0]    addr_s;

    exp_t q[$];
    exp_t qs[$];
    exp_t e;
    exp_t es;
    logic [7:0] lfsr = 8'hB7;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_addr, prev_data;

    pooled_pixel_streamer dut (
        .clk(clk), .reset(reset), .start(start), .pixels_averaged(pix),
        .busy(busy), .pixel_out(pixel_out), .pixel_addr(pixel_addr),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .last(last), .done(done)
    );

    pooled_pixel_streamer #(.resolution(4), .pixels_number(16)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .pixels_averaged(pix_s),
        .busy(busy_s), .pixel_out(out_s), .pixel_addr(addr_s),
        .pixel_valid(valid_s), .pixel_ready(ready_s), .last(last_s), .done(done_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s", name);
    endtask

    // Main-instance monitor: pops on every transfer, checks hold under stall
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", pixel_valid, 1);
                check("hold_addr", pixel_addr, prev_addr);
                check("hold_data", pixel_out, prev_data);
            end
            if (pixel_valid && pixel_ready) begin
                if (q.size() == 0) begin
                    fail_now($sformatf("spurious_xfer addr=%0d", pixel_addr));
                end else begin
                    e = q.pop_front();
                    check($sformatf("addr@%0d", e.addr), pixel_addr, e.addr);
                    check($sformatf("data@%0d", e.addr), pixel_out, e.data);
                    check($sformatf("last@%0d", e.addr), last, e.last);
                end
            end else if (!pixel_valid) begin
                check("idle_out_zero", pixel_out, 0);
                check("idle_last_zero", last, 0);
            end
            prev_stall = pixel_valid && !pixel_ready;
            prev_addr  = pixel_addr;
            prev_data  = pixel_out;
        end
    end

    // Small-instance monitor
    always @(negedge clk) begin
        if (!reset && valid_s && ready_s) begin
            if (qs.size() == 0) begin
                fail_now($sformatf("small_spurious_xfer addr=%0d", addr_s));
            end else begin
                es = qs.pop_front();
                check($sformatf("small_addr@%0d", es.addr), addr_s, es.addr);
                check($sformatf("small_data@%0d", es.addr), out_s, es.data);
                check($sformatf("small_last@%0d", es.addr), last_s, es.last);
            end
        end
    end

    task automatic push_frame(input int count);
        for (int i = 0; i < count; i++)
            q.push_back('{addr: 8'(i), data: pix[i*8 +: 8], last: (i == 195)});
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        check("pre_start_valid", pixel_valid, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("first_valid", pixel_valid, 1);
        check("first_addr", pixel_addr, 0);
    endtask

    // Runs from just after the start edge until the edge leaving DONE
    task automatic run_frame(input bit bp, input bit flip, input bit start50, input bit chain,
                             output int busy_cnt, output int done_cnt, output int done_at);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (bp) begin
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                pixel_ready = lfsr[0];
            end else begin
                pixel_ready = 1'b1;
            end
            if (flip) pix = '1;
            start = (start50 && pixel_valid && pixel_addr == 8'd50) || (chain && done);
            @(negedge clk);
            busy_cnt += int'(busy);
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            @(posedge clk); #1;
            if (done_at >= 0) break;
        end
        if (done_at < 0) fail_now("frame_timeout");
        pixel_ready = 1'b1;
        if (!chain) start = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_cnt, done_at, small_busy, small_done;

        // Reset state
        #3;
        check("rst_busy", busy, 0);
        check("rst_valid", pixel_valid, 0);
        check("rst_out", pixel_out, 0);
        check("rst_addr", pixel_addr, 0);
        check("rst_last", last, 0);
        check("rst_done", done, 0);
        #19 reset = 1'b0;

        // Frame A: pixel i = i, ready held high
        for (int i = 0; i < 196; i++) pix[i*8 +: 8] = 8'(i);
        push_frame(196);
        do_start();
        run_frame(0, 0, 0, 0, busy_cnt, done_cnt, done_at);
        check("A_busy_cycles", busy_cnt, 197);
        check("A_done_at", done_at, 196);
        check("A_done_count", done_cnt, 1);
        check("A_drained", q.size(), 0);
        check("A_idle_busy", busy, 0);

        // Frame B: backpressure, 0xA5 everywhere except pixel 100 = 0x3C
        for (int i = 0; i < 196; i++) pix[i*8 +: 8] = 8'hA5;
        pix[100*8 +: 8] = 8'h3C;
        push_frame(196);
        do_start();
        run_frame(1, 0, 0, 0, busy_cnt, done_cnt, done_at);
        check("B_done_after_last", done_at, busy_cnt - 1);
        check("B_done_count", done_cnt, 1);
        check("B_drained", q.size(), 0);

        // Frame C: input overwritten after capture, start at addr 50 and in DONE
        for (int i = 0; i < 196; i++) pix[i*8 +: 8] = 8'((i * 7 + 3) & 8'hFF);
        push_frame(196);
        do_start();
        run_frame(0, 1, 1, 1, busy_cnt, done_cnt, done_at);
        check("C_busy_cycles", busy_cnt, 197);
        check("C_done_count", done_cnt, 1);
        check("C_drained", q.size(), 0);
        check("C_done_start_ignored_valid", pixel_valid, 0);
        check("C_done_start_ignored_busy", busy, 0);

        // Frame D: start held in the cycle after done is accepted (input is all 0xFF)
        push_frame(196);
        @(posedge clk); #1;
        start = 1'b0;
        check("D_valid_after_start", pixel_valid, 1);
        check("D_addr_after_start", pixel_addr, 0);
        run_frame(0, 0, 0, 0, busy_cnt, done_cnt, done_at);
        check("D_busy_cycles", busy_cnt, 197);
        check("D_drained", q.size(), 0);

        // Frame E: async reset between edges at address 77
        for (int i = 0; i < 196; i++) pix[i*8 +: 8] = 8'((i * 3) & 8'hFF);
        push_frame(77);
        do_start();
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (pixel_valid && pixel_addr == 8'd77) break;
            @(posedge clk); #1;
        end
        check("E_reached_77", pixel_addr, 77);
        #2 reset = 1'b1;
        #1;
        check("E_rst_valid", pixel_valid, 0);
        check("E_rst_busy", busy, 0);
        check("E_rst_last", last, 0);
        check("E_rst_done", done, 0);
        check("E_rst_addr", pixel_addr, 0);
        check("E_rst_out", pixel_out, 0);
        check("E_drained", q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("E_no_done", done, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("E_idle_after_rst", busy, 0);
        end
        push_frame(196);
        do_start();
        run_frame(0, 0, 0, 0, busy_cnt, done_cnt, done_at);
        check("E_fresh_busy_cycles", busy_cnt, 197);
        check("E_fresh_drained", q.size(), 0);

        // Small instance: 4-bit pixels, 16 per frame
        for (int i = 0; i < 16; i++) pix_s[i*4 +: 4] = 4'(i ^ 5);
        for (int i = 0; i < 16; i++)
            qs.push_back('{addr: 8'(i), data: 8'(i ^ 5), last: (i == 15)});
        @(posedge clk); #1;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        check("small_first_valid", valid_s, 1);
        small_busy = 0;
        small_done = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            small_busy += int'(busy_s);
            small_done += int'(done_s);
        end
        check("small_busy_cycles", small_busy, 17);
        check("small_done_count", small_done, 1);
        check("small_drained", qs.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
